// File: rtl/block_interleaver_if.sv
// Codeword-in / interleaved-block-out bus for block_interleaver.
// slave is the interleaver's view; master is the driving environment's view.
interface block_interleaver_if #(
  parameter int n          = 7,
  parameter int symbol_num = 4,
  parameter int CNT_W      = 16
);
  logic                      cw_valid;
  logic [n-1:0]              cw_data;
  logic                      cw_ready;
  logic                      flush;
  logic                      t_valid;
  logic [n*symbol_num-1:0]   t_data;
  logic                      t_ready;
  logic                      t_padded;
  logic [CNT_W-1:0]          blk_cnt;

  modport slave (
    input  cw_valid, cw_data, flush, t_ready,
    output cw_ready, t_valid, t_data, t_padded, blk_cnt
  );

  modport master (
    output cw_valid, cw_data, flush, t_ready,
    input  cw_ready, t_valid, t_data, t_padded, blk_cnt
  );
endinterface

// File: rtl/block_interleaver.sv
// Ping-pong block interleaver: gathers symbol_num n-bit codewords per bank and
// presents each full bank with codeword i bit j at t_data[j*symbol_num + i].
module block_interleaver #(
  parameter int n          = 7,
  parameter int symbol_num = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  block_interleaver_if.slave    bus
);

  localparam int                IDX_W    = (symbol_num > 1) ? $clog2(symbol_num) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(symbol_num - 1);

  typedef logic [n-1:0] cw_t;

  cw_t              bank_q [2][symbol_num];
  cw_t              bank_d [2][symbol_num];
  logic [1:0]       full_q, full_d;
  logic [1:0]       padded_q, padded_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  logic                    wr_open;
  logic                    accept;
  logic                    last_slot;
  logic                    flush_take;
  logic                    close_blk;
  logic                    drain;
  logic [n*symbol_num-1:0] t_data_c;

  assign wr_open   = ~full_q[wr_sel_q];
  assign accept    = bus.cw_valid & wr_open;
  assign last_slot = (wr_idx_q == LAST_IDX);
  // A flush only closes a block that holds data and that the same-cycle write did not complete.
  assign flush_take = bus.flush & wr_open & ~(accept & last_slot)
                    & (accept | (wr_idx_q != '0));
  assign close_blk  = (accept & last_slot) | flush_take;
  assign drain      = full_q[rd_sel_q] & bus.t_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    full_d    = full_q;
    padded_d  = padded_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    wr_idx_d  = wr_idx_q;
    blk_cnt_d = blk_cnt_q;

    if (drain) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
      blk_cnt_d        = blk_cnt_q + CNT_W'(1);
    end

    if (close_blk) begin
      full_d[wr_sel_q]   = 1'b1;
      padded_d[wr_sel_q] = flush_take;
      wr_sel_d           = ~wr_sel_q;
      wr_idx_d           = '0;
    end else if (accept) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    bank_d = bank_q;
    for (int s = 0; s < symbol_num; s++) begin
      if (accept && (wr_idx_q == IDX_W'(s))) begin
        bank_d[wr_sel_q][s] = bus.cw_data;
      end else if (flush_take && (IDX_W'(s) >= wr_idx_q)) begin
        bank_d[wr_sel_q][s] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      padded_q  <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      wr_idx_q  <= '0;
      blk_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      full_q    <= full_d;
      padded_q  <= padded_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      wr_idx_q  <= wr_idx_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  // NOTE: bank storage is not reset; t_data is gated by the full flag so stale words never leak out.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  always_comb begin
    t_data_c = '0;
    if (full_q[rd_sel_q]) begin
      for (int i = 0; i < symbol_num; i++) begin
        for (int j = 0; j < n; j++) begin
          t_data_c[j*symbol_num + i] = bank_q[rd_sel_q][i][j];
        end
      end
    end
  end

  assign bus.cw_ready = wr_open;
  assign bus.t_valid  = full_q[rd_sel_q];
  assign bus.t_data   = t_data_c;
  assign bus.t_padded = padded_q[rd_sel_q] & full_q[rd_sel_q];
  assign bus.blk_cnt  = blk_cnt_q;

endmodule

// File: tb/tb_block_interleaver.sv
// Bench for block_interleaver: directed literal cases plus a queue-based block model
// checked through the receive-side deinterleave mapping on every cycle.
module tb_block_interleaver;

  localparam int N  = 7;
  localparam int S  = 4;
  localparam int CW = 4;
  localparam int W  = N * S;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  block_interleaver_if #(.n(N), .symbol_num(S), .CNT_W(CW)) bus ();

  block_interleaver #(.n(N), .symbol_num(S), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receive-side mapping: in[j*S+i] -> out[i*N+j], giving {cw3,cw2,cw1,cw0}.
  function automatic logic [W-1:0] deinterleave(input logic [W-1:0] t);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < N; j++)
        o[i*N + j] = t[j*S + i];
    return o;
  endfunction

  // Block-level model: whole blocks as {cw3..cw0}, pending in hand-off order.
  logic [W-1:0]  exp_q [$];
  logic          pad_q [$];
  logic [N-1:0]  part_q [$];
  logic [CW-1:0] m_cnt    = '0;
  int            m_drains = 0;

  always @(negedge rst_n) begin
    exp_q.delete();
    pad_q.delete();
    part_q.delete();
    m_cnt = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit           rdy;
      logic [W-1:0] blk;
      rdy = (exp_q.size() < 2);
      if (exp_q.size() > 0 && bus.t_ready) begin
        exp_q.delete(0);
        pad_q.delete(0);
        m_cnt++;
        m_drains++;
      end
      if (bus.cw_valid && rdy) begin
        part_q.push_back(bus.cw_data);
        if (part_q.size() == S) begin
          blk = '0;
          foreach (part_q[k]) blk[k*N +: N] = part_q[k];
          exp_q.push_back(blk);
          pad_q.push_back(1'b0);
          part_q.delete();
        end
      end
      if (bus.flush && rdy && part_q.size() > 0) begin
        blk = '0;
        foreach (part_q[k]) blk[k*N +: N] = part_q[k];
        exp_q.push_back(blk);
        pad_q.push_back(1'b1);
        part_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model cw_ready", bus.cw_ready, exp_q.size() < 2);
      check("model t_valid",  bus.t_valid,  exp_q.size() > 0);
      check("model blk_cnt",  bus.blk_cnt,  m_cnt);
      if (exp_q.size() > 0) begin
        check("model round trip", deinterleave(bus.t_data), exp_q[0]);
        check("model t_padded",   bus.t_padded,             pad_q[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cw(input logic [N-1:0] d);
    int waited;
    waited = 0;
    bus.cw_valid = 1'b1;
    bus.cw_data  = d;
    while (!bus.cw_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("send_cw accepted in time", waited < 50, 1'b1);
    tick();
    bus.cw_valid = 1'b0;
  endtask

  task automatic run_block(input logic [N-1:0] c0, input logic [N-1:0] c1,
                           input logic [N-1:0] c2, input logic [N-1:0] c3,
                           input logic [W-1:0] exp, input string nm);
    bus.t_ready = 1'b1;
    send_cw(c0);
    send_cw(c1);
    send_cw(c2);
    send_cw(c3);
    check({nm, " t_valid"},  bus.t_valid,  1'b1);
    check({nm, " t_data"},   bus.t_data,   exp);
    check({nm, " t_padded"}, bus.t_padded, 1'b0);
    tick();
    check({nm, " drained"},  bus.t_valid,  1'b0);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    int cycles;
    int start_drains;
    bus.cw_valid = 1'b0;
    bus.cw_data  = '0;
    bus.flush    = 1'b0;
    bus.t_ready  = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset t_valid",  bus.t_valid,  1'b0);
    check("reset cw_ready", bus.cw_ready, 1'b1);
    check("reset t_data",   bus.t_data,   28'h0);
    check("reset t_padded", bus.t_padded, 1'b0);
    check("reset blk_cnt",  bus.blk_cnt,  4'd0);
    rst_n = 1'b1;
    tick();

    // Single-slot patterns pin the bit mapping.
    check("blk_cnt before first", bus.blk_cnt, 4'd0);
    run_block(7'h7F, 7'h00, 7'h00, 7'h00, 28'h1111111, "slot0 ones");
    check("blk_cnt after first", bus.blk_cnt, 4'd1);
    run_block(7'h00, 7'h00, 7'h00, 7'h7F, 28'h8888888, "slot3 ones");
    run_block(7'h00, 7'h01, 7'h00, 7'h00, 28'h0000002, "slot1 bit0");

    // Partial block closed by flush.
    send_cw(7'h7F);
    pulse_flush();
    check("flush partial t_valid",  bus.t_valid,  1'b1);
    check("flush partial t_data",   bus.t_data,   28'h1111111);
    check("flush partial t_padded", bus.t_padded, 1'b1);
    tick();

    // Flush coinciding with the completing codeword is ignored.
    send_cw(7'h01);
    send_cw(7'h02);
    send_cw(7'h03);
    bus.cw_valid = 1'b1;
    bus.cw_data  = 7'h04;
    bus.flush    = 1'b1;
    tick();
    bus.cw_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush+last t_valid",  bus.t_valid,  1'b1);
    check("flush+last t_data",   bus.t_data,   28'h0000865);
    check("flush+last t_padded", bus.t_padded, 1'b0);
    tick();
    check("flush+last one block", bus.t_valid, 1'b0);
    repeat (3) tick();
    check("flush+last still empty", bus.t_valid, 1'b0);
    check("blk_cnt after flush tests", bus.blk_cnt, 4'd5);

    // Backpressure: two banks fill, ninth codeword waits for the first drain.
    bus.t_ready  = 1'b0;
    bus.cw_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.cw_data = N'(k + 1);
      check("bp ready while filling", bus.cw_ready, 1'b1);
      tick();
    end
    bus.cw_data = 7'h09;
    check("bp both full ready", bus.cw_ready, 1'b0);
    check("bp block0 valid",    bus.t_valid,  1'b1);
    check("bp block0 data",     bus.t_data,   28'h0000865);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp block0 stable", bus.t_data,   28'h0000865);
      check("bp still stalled", bus.cw_ready, 1'b0);
    end
    bus.t_ready = 1'b1;
    tick();
    check("bp ready after drain", bus.cw_ready, 1'b1);
    check("bp block1 valid",      bus.t_valid,  1'b1);
    check("bp block1 data",       bus.t_data,   28'h0008765);
    tick();
    bus.cw_valid = 1'b0;
    check("bp ninth held as partial", bus.t_valid, 1'b0);
    pulse_flush();
    check("bp ninth flushed data",   bus.t_data,   28'h0001001);
    check("bp ninth flushed padded", bus.t_padded, 1'b1);
    tick();
    check("blk_cnt after bp", bus.blk_cnt, 4'd8);

    // Reset mid-block.
    send_cw(7'h7F);
    send_cw(7'h7F);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid-block t_valid",  bus.t_valid,  1'b0);
    check("rst mid-block cw_ready", bus.cw_ready, 1'b1);
    check("rst mid-block blk_cnt",  bus.blk_cnt,  4'd0);
    check("rst mid-block t_data",   bus.t_data,   28'h0);
    tick();
    rst_n = 1'b1;

    // Reset while a block waits for t_ready.
    bus.t_ready = 1'b0;
    send_cw(7'h7F);
    send_cw(7'h7F);
    send_cw(7'h7F);
    send_cw(7'h7F);
    check("rst stalled pre t_valid", bus.t_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst stalled t_valid",  bus.t_valid,  1'b0);
    check("rst stalled cw_ready", bus.cw_ready, 1'b1);
    check("rst stalled blk_cnt",  bus.blk_cnt,  4'd0);
    check("rst stalled t_padded", bus.t_padded, 1'b0);
    tick();
    rst_n = 1'b1;
    run_block(7'h7F, 7'h00, 7'h00, 7'h00, 28'h1111111, "post-reset clean");

    // Counter wrap with a 4-bit counter: 17 blocks leave 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.t_ready = 1'b1;
    for (int b = 0; b < 17; b++) begin
      send_cw(N'(b));
      send_cw(N'(b * 3));
      send_cw(N'(~b));
      send_cw(N'(b + 64));
    end
    tick();
    check("wrap blk_cnt", bus.blk_cnt, 4'd1);
    check("wrap drained", bus.t_valid, 1'b0);

    // Random traffic: 1000 blocks through the model's deinterleave check.
    start_drains = m_drains;
    cycles = 0;
    while ((m_drains - start_drains) < 1000 && cycles < 30000) begin
      bus.cw_valid = ($urandom % 10) < 7;
      bus.cw_data  = N'($urandom);
      bus.t_ready  = ($urandom % 10) < 6;
      bus.flush    = ($urandom % 50) == 0;
      tick();
      cycles++;
    end
    check("random 1000 blocks in budget", (m_drains - start_drains) >= 1000, 1'b1);
    bus.cw_valid = 1'b0;
    bus.t_ready  = 1'b1;
    pulse_flush();
    repeat (4) tick();
    check("random final drain", bus.t_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
